single_cycle_top: RTL and testbench
===================================

# single_cycle_top

Top level of the RV32I single-cycle processor: a self-contained core that fetches, decodes, executes, accesses memory and writes back one instruction per clock. It integrates the program counter, instruction memory, register file, immediate generator, control decoder, ALU and data memory. It has no external data ports; verification observes PC, register file and data memory through hierarchical references. It is the root of the single-cycle design and is driven only by a clock and a reset.

## Interface
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 32-bit words.
- IMEM_FILE, "memfile.hex", hex image loaded into instruction memory at time 0 (one word per line).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.

## Operation
- Instruction fetch: the word at instruction memory index PC[31:2] is read combinationally.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLL, SRL. Shift amount is rs2[4:0].
  - I-type ALU: ADDI, ANDI, ORI, XORI, SLTI.
  - Loads and stores: LW, SW.
  - Branches: BEQ, BNE.
  - Jumps and upper immediates: JAL, LUI.
- Immediates are sign-extended per the RV32I I/S/B/J formats. U-type is imm[31:12]<<12.
- Register file:
  - 32x32 bits with two combinational read ports and one write port.
  - x0 always reads 0; writes to x0 are discarded.
- ALU:
  - 32-bit, two's complement, wrap-around.
  - SLT/SLTI is a signed compare producing 1 or 0.
  - Zero flag = (result == 0).
- Data memory:
  - Word-addressed by ALU result[31:2]; address bits [1:0] are ignored.
  - Read is combinational; write is synchronous.
  - Addresses beyond DMEM_WORDS wrap modulo depth.
- Write-back source, per instruction class:
  - ALU ops: ALU result.
  - LW: memory data.
  - JAL: PC+4.
  - LUI: the immediate.
- Next PC:
  - Default: PC+4.
  - BEQ taken (zero=1) or BNE taken (zero=0): PC+immB.
  - JAL: PC+immJ.
- Any unsupported opcode executes as a NOP: no register write, no memory write, next PC = PC+4.

## Timing
- One instruction per cycle. Register and memory writes commit on the rising edge that ends the instruction's cycle.
- Reset behaviour:
  - While rst=1 at a rising edge: PC←0, all 32 registers←0, and register and memory writes are suppressed.
  - Data memory contents are not cleared by reset; they are zero at time 0.
  - Instruction memory is never modified.
- First instruction: the instruction at address 0 executes in the first cycle after rst is sampled low. Its results are visible after the next rising edge.
- Reset mid-program: asserting rst for one edge aborts the current instruction (no commit) and restarts at PC=0 with cleared registers.
- PC wraps at 2^32. Instruction fetch uses PC[31:2] modulo IMEM_WORDS.
- Combinational depth: fetch → decode → regfile read → ALU → data memory → write-back mux, completing in one period.

## Test plan
- Reset:
  - Stimulus: hold rst=1 for 2 edges, then release.
  - Required: PC=0 and x1..x31=0 during reset; PC=4 one edge after release.
- Arithmetic:
  - Stimulus: program addi x1,x0,5; addi x2,x0,10; add x3,x1,x2; sub x4,x1,x2.
  - Required, after 4 edges: x1=5, x2=10, x3=15, x4=0xFFFFFFFB.
  - Stimulus: slt x5,x4,x1. Required: x5=1.
- Memory:
  - Stimulus: sw x3,8(x0); lw x6,8(x0).
  - Required: data memory word 2 = 15; x6=15. The sw cycle writes no register.
- Branch and jump:
  - Stimulus: beq x1,x1,+8 at PC=0x20.
  - Required: next PC=0x28, skipped instruction has no effect.
  - Stimulus: bne x1,x1,+8. Required: PC+4.
  - Stimulus: jal x7,-16 at 0x30. Required: x7=0x34, PC=0x20.
- x0 and LUI:
  - Stimulus: addi x0,x0,7.
  - Required: x0 still reads 0.
  - Stimulus: lui x8,0x12345. Required: x8=0x12345000.
- Mid-program reset:
  - Stimulus: assert rst for one edge during the add instruction.
  - Required: x3 not written, PC=0, all registers 0; the program re-executes identically afterwards.

Source files
------------

// File: rtl/single_cycle_top.sv
// single_cycle_top: RV32I single-cycle core that fetches, decodes, executes, accesses memory and writes back one instruction per clock
module single_cycle_top #(
  parameter int    IMEM_WORDS = 1024,
  parameter int    DMEM_WORDS = 1024,
  parameter string IMEM_FILE  = "memfile.hex"
) (
  input  logic clk,
  input  logic rst
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LW  = 7'h03;
  localparam logic [6:0] OP_SW  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f;
  localparam logic [6:0] OP_LUI = 7'h37;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL} alu_op_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
  logic [31:0]    r_pc;
  logic [31:0]    r_regs [32];
  logic [31:0]    r_imem [IMEM_WORDS];
  logic [31:0]    r_dmem [DMEM_WORDS];
  logic [IAW-1:0] w_iaddr;
  logic [DAW-1:0] w_daddr;
  logic [31:0]    w_instr;
  logic [6:0]     w_op;
  logic [4:0]     w_rd;
  logic [4:0]     w_rs1;
  logic [4:0]     w_rs2;
  logic [2:0]     w_f3;
  logic [6:0]     w_f7;
  logic [31:0]    w_imm_i;
  logic [31:0]    w_imm_s;
  logic [31:0]    w_imm_b;
  logic [31:0]    w_imm_j;
  logic [31:0]    w_imm_u;
  logic           w_r_ok;
  logic           w_i_ok;
  logic           w_reg_we;
  logic           w_mem_we;
  logic           w_b_imm;
  logic           w_b_store;
  logic           w_branch;
  logic           w_bne;
  logic           w_jump;
  alu_op_e        w_alu_op;
  wb_sel_e        w_wb_sel;
  logic [31:0]    w_rs1_val;
  logic [31:0]    w_rs2_val;
  logic [31:0]    w_alu_b;
  logic [31:0]    w_alu;
  logic           w_zero;
  logic [31:0]    w_rdata;
  logic [31:0]    w_pc4;
  logic [31:0]    w_wb;
  logic [31:0]    w_pc_next;

  function automatic alu_op_e f3_op(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign w_iaddr = IAW'(r_pc[31:2] % 30'(IMEM_WORDS));
  assign w_instr = r_imem[w_iaddr];
  assign w_op    = w_instr[6:0];
  assign w_rd    = w_instr[11:7];
  assign w_f3    = w_instr[14:12];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];
  assign w_f7    = w_instr[31:25];
  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_r_ok  = (w_f7 == 7'h00 && w_f3 != 3'd3) || (w_f7 == 7'h20 && w_f3 == 3'd0);
  assign w_i_ok  = w_f3 != 3'd1 && w_f3 != 3'd3 && w_f3 != 3'd5;

  // Control decode: any encoding outside the supported subset leaves every control low and so runs as a NOP
  always_comb begin
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_b_imm   = 1'b0;
    w_b_store = 1'b0;
    w_branch  = 1'b0;
    w_bne     = 1'b0;
    w_jump    = 1'b0;
    w_alu_op  = ALU_ADD;
    w_wb_sel  = WB_ALU;
    case (w_op)
      OP_R: begin
        w_reg_we = w_r_ok;
        w_alu_op = f3_op(w_f3, w_f7[5]);
      end
      OP_I: begin
        w_reg_we = w_i_ok;
        w_b_imm  = 1'b1;
        w_alu_op = f3_op(w_f3, 1'b0);
      end
      OP_LW: begin
        w_reg_we = w_f3 == 3'd2;
        w_b_imm  = 1'b1;
        w_wb_sel = WB_MEM;
      end
      OP_SW: begin
        w_mem_we  = w_f3 == 3'd2;
        w_b_imm   = 1'b1;
        w_b_store = 1'b1;
      end
      OP_BR: begin
        w_branch = w_f3 == 3'd0 || w_f3 == 3'd1;
        w_bne    = w_f3[0];
        w_alu_op = ALU_SUB;
      end
      OP_JAL: begin
        w_reg_we = 1'b1;
        w_jump   = 1'b1;
        w_wb_sel = WB_PC4;
      end
      OP_LUI: begin
        w_reg_we = 1'b1;
        w_wb_sel = WB_IMM;
      end
      default: w_reg_we = 1'b0;
    endcase
  end

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
  assign w_alu_b   = w_b_store ? w_imm_s : w_b_imm ? w_imm_i : w_rs2_val;

  // ALU: wrap-around arithmetic, signed SLT, shift amount from the low five bits of operand B
  always_comb begin
    case (w_alu_op)
      ALU_SUB: w_alu = w_rs1_val - w_alu_b;
      ALU_AND: w_alu = w_rs1_val & w_alu_b;
      ALU_OR:  w_alu = w_rs1_val | w_alu_b;
      ALU_XOR: w_alu = w_rs1_val ^ w_alu_b;
      ALU_SLT: w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
      ALU_SLL: w_alu = w_rs1_val << w_alu_b[4:0];
      ALU_SRL: w_alu = w_rs1_val >> w_alu_b[4:0];
      default: w_alu = w_rs1_val + w_alu_b;
    endcase
  end

  assign w_zero    = w_alu == 32'd0;
  assign w_daddr   = DAW'(w_alu[31:2] % 30'(DMEM_WORDS));
  assign w_rdata   = r_dmem[w_daddr];
  assign w_pc4     = r_pc + 32'd4;
  assign w_wb      = (w_wb_sel == WB_MEM) ? w_rdata : (w_wb_sel == WB_PC4) ? w_pc4 : (w_wb_sel == WB_IMM) ? w_imm_u : w_alu;
  assign w_pc_next = w_jump ? r_pc + w_imm_j : (w_branch && (w_zero ^ w_bne)) ? r_pc + w_imm_b : w_pc4;

  // Program counter: restart at 0 on reset, otherwise follow the next-PC selection
  always_ff @(posedge clk) r_pc <= rst ? 32'd0 : w_pc_next;

  // Register file: reset clears every entry; writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (rst)
      for (int k = 0; k < 32; k++) r_regs[k] <= 32'd0;
    else if (w_reg_we && w_rd != 5'd0)
      r_regs[w_rd] <= w_wb;
  end

  // Data memory: contents survive reset, only stores are blocked while it is asserted
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) r_dmem[w_daddr] <= w_rs2_val;
  end
endmodule

// File: tb/tb_single_cycle_top.sv
// tb_single_cycle_top: directed vector table plus randomized programs checked against an instruction-level model
module tb_single_cycle_top;
  localparam int IW = 1024;
  localparam int DW = 1024;
  localparam int N  = 48;
  typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLT, K_SLL, K_SRL,
                    K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_LW, K_SW,
                    K_BEQ, K_BNE, K_JAL, K_LUI, K_NOP} kind_e;
  typedef struct {kind_e k; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic [31:0] imm;} ins_t;
  typedef struct {logic [31:0] pc; int rg; logic [31:0] val; int dm; logic [31:0] dval;} vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  ins_t        prog [IW];
  logic [31:0] mr [32];
  logic [31:0] mm [DW];
  logic [31:0] mpc;
  vec_t        tv [13];

  single_cycle_top #(.IMEM_WORDS(IW), .DMEM_WORDS(DW), .IMEM_FILE("memfile.hex")) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  function automatic ins_t mk(kind_e k, int rd, int rs1, int rs2, logic [31:0] imm);
    ins_t x;
    x.k = k; x.rd = 5'(rd); x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.imm = imm;
    return x;
  endfunction

  function automatic logic [31:0] enc(ins_t x);
    logic [31:0] m;
    m = x.imm;
    case (x.k)
      K_ADD:  return {7'h00, x.rs2, x.rs1, 3'd0, x.rd, 7'h33};
      K_SUB:  return {7'h20, x.rs2, x.rs1, 3'd0, x.rd, 7'h33};
      K_SLL:  return {7'h00, x.rs2, x.rs1, 3'd1, x.rd, 7'h33};
      K_SLT:  return {7'h00, x.rs2, x.rs1, 3'd2, x.rd, 7'h33};
      K_XOR:  return {7'h00, x.rs2, x.rs1, 3'd4, x.rd, 7'h33};
      K_SRL:  return {7'h00, x.rs2, x.rs1, 3'd5, x.rd, 7'h33};
      K_OR:   return {7'h00, x.rs2, x.rs1, 3'd6, x.rd, 7'h33};
      K_AND:  return {7'h00, x.rs2, x.rs1, 3'd7, x.rd, 7'h33};
      K_ADDI: return {m[11:0], x.rs1, 3'd0, x.rd, 7'h13};
      K_SLTI: return {m[11:0], x.rs1, 3'd2, x.rd, 7'h13};
      K_XORI: return {m[11:0], x.rs1, 3'd4, x.rd, 7'h13};
      K_ORI:  return {m[11:0], x.rs1, 3'd6, x.rd, 7'h13};
      K_ANDI: return {m[11:0], x.rs1, 3'd7, x.rd, 7'h13};
      K_LW:   return {m[11:0], x.rs1, 3'd2, x.rd, 7'h03};
      K_SW:   return {m[11:5], x.rs2, x.rs1, 3'd2, m[4:0], 7'h23};
      K_BEQ:  return {m[12], m[10:5], x.rs2, x.rs1, 3'd0, m[4:1], m[11], 7'h63};
      K_BNE:  return {m[12], m[10:5], x.rs2, x.rs1, 3'd1, m[4:1], m[11], 7'h63};
      K_JAL:  return {m[20], m[10:1], m[11], m[19:12], x.rd, 7'h6f};
      K_LUI:  return {m[19:0], x.rd, 7'h37};
      default: return m;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < 32; i++) if (bad < 0 && dut.r_regs[i] !== mr[i]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s: x%0d got %h want %h", nm, bad, dut.r_regs[bad], mr[bad]);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < IW; i++) dut.r_imem[i] = enc(prog[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IW; i++) prog[i] = mk(K_NOP, 0, 0, 0, 32'd0);
  endtask

  // Instruction-level reference: executes one decoded record and updates architectural state
  task automatic model_step();
    ins_t x;
    logic [31:0] a, b, npc, ea, v;
    bit wr;
    int di;
    x = prog[(mpc >> 2) % IW];
    a = mr[x.rs1];
    b = mr[x.rs2];
    npc = mpc + 4;
    ea = a + x.imm;
    di = int'((ea >> 2) % DW);
    wr = 1;
    v = 0;
    case (x.k)
      K_ADD:  v = a + b;
      K_SUB:  v = a - b;
      K_AND:  v = a & b;
      K_OR:   v = a | b;
      K_XOR:  v = a ^ b;
      K_SLT:  v = ($signed(a) < $signed(b)) ? 1 : 0;
      K_SLL:  v = a << b[4:0];
      K_SRL:  v = a >> b[4:0];
      K_ADDI: v = a + x.imm;
      K_ANDI: v = a & x.imm;
      K_ORI:  v = a | x.imm;
      K_XORI: v = a ^ x.imm;
      K_SLTI: v = ($signed(a) < $signed(x.imm)) ? 1 : 0;
      K_LW:   v = mm[di];
      K_SW:   begin mm[di] = b; wr = 0; end
      K_BEQ:  begin wr = 0; if (a == b) npc = mpc + x.imm; end
      K_BNE:  begin wr = 0; if (a != b) npc = mpc + x.imm; end
      K_JAL:  begin v = mpc + 4; npc = mpc + x.imm; end
      K_LUI:  v = x.imm << 12;
      default: wr = 0;
    endcase
    if (wr && x.rd != 0) mr[x.rd] = v;
    mpc = npc;
  endtask

  function automatic logic [31:0] sx12();
    logic [31:0] r;
    r = $urandom;
    return {{20{r[11]}}, r[11:0]};
  endfunction

  task automatic gen_prog();
    logic [6:0] bad [5];
    logic [31:0] r;
    kind_e k;
    int t;
    bad = '{7'h00, 7'h0f, 7'h17, 7'h67, 7'h73};
    clear_prog();
    for (int c = 0; c < N; c++) begin
      k = kind_e'($urandom_range(0, 19));
      prog[c] = mk(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), sx12());
      if (k == K_SW || k == K_LW) prog[c].rs1 = ($urandom_range(0, 1) == 1) ? 5'd0 : prog[c].rs1;
      if (k == K_BEQ || k == K_BNE) prog[c].rs2 = ($urandom_range(0, 1) == 1) ? prog[c].rs1 : prog[c].rs2;
      if (k == K_BEQ || k == K_BNE || k == K_JAL) begin
        t = $urandom_range(0, N - 1);
        if (t == c) t = (c + 1) % N;
        prog[c].imm = 32'((t - c) * 4);
      end
      if (k == K_LUI) prog[c].imm = $urandom & 32'hfffff;
      if (k == K_NOP) begin
        r = $urandom;
        prog[c].imm = {r[31:7], bad[$urandom_range(0, 4)]};
      end
    end
  endtask

  initial begin
    clear_prog();
    prog[0]  = mk(K_ADDI, 1, 0, 0, 32'd5);
    prog[1]  = mk(K_ADDI, 2, 0, 0, 32'd10);
    prog[2]  = mk(K_ADD,  3, 1, 2, 32'd0);
    prog[3]  = mk(K_SUB,  4, 1, 2, 32'd0);
    prog[4]  = mk(K_SLT,  5, 4, 1, 32'd0);
    prog[5]  = mk(K_SW,   0, 0, 3, 32'd8);
    prog[6]  = mk(K_LW,   6, 0, 0, 32'd8);
    prog[7]  = mk(K_ADDI, 0, 0, 0, 32'd7);
    prog[8]  = mk(K_BEQ,  0, 1, 1, 32'd8);
    prog[9]  = mk(K_ADDI, 9, 0, 0, 32'd99);
    prog[10] = mk(K_BNE,  0, 1, 1, 32'd8);
    prog[11] = mk(K_LUI,  8, 0, 0, 32'h12345);
    prog[12] = mk(K_JAL,  7, 0, 0, 32'hfffffff0);
    load_prog();
    tv[0]  = '{32'h04, 1, 32'd5,        -1, 32'd0};
    tv[1]  = '{32'h08, 2, 32'd10,       -1, 32'd0};
    tv[2]  = '{32'h0c, 3, 32'd15,       -1, 32'd0};
    tv[3]  = '{32'h10, 4, 32'hfffffffb, -1, 32'd0};
    tv[4]  = '{32'h14, 5, 32'd1,        -1, 32'd0};
    tv[5]  = '{32'h18, 6, 32'd0,         2, 32'd15};
    tv[6]  = '{32'h1c, 6, 32'd15,       -1, 32'd0};
    tv[7]  = '{32'h20, 0, 32'd0,        -1, 32'd0};
    tv[8]  = '{32'h28, 9, 32'd0,        -1, 32'd0};
    tv[9]  = '{32'h2c, 1, 32'd5,        -1, 32'd0};
    tv[10] = '{32'h30, 8, 32'h12345000, -1, 32'd0};
    tv[11] = '{32'h20, 7, 32'h34,       -1, 32'd0};
    tv[12] = '{32'h28, 7, 32'h34,        2, 32'd15};
    for (int i = 0; i < 32; i++) mr[i] = 32'd0;
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      step();
      chk("reset_pc", dut.r_pc, 32'd0);
      chk_regs("reset_regs");
    end
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("vec%0d_pc", i), dut.r_pc, tv[i].pc);
      chk($sformatf("vec%0d_x%0d", i, tv[i].rg), dut.r_regs[tv[i].rg], tv[i].val);
      if (tv[i].dm >= 0) chk($sformatf("vec%0d_dmem", i), dut.r_dmem[tv[i].dm], tv[i].dval);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    chk("pre_midrst_pc", dut.r_pc, 32'h8);
    rst = 1'b1;
    step();
    chk("midrst_pc", dut.r_pc, 32'd0);
    chk("midrst_x3", dut.r_regs[3], 32'd0);
    chk_regs("midrst_regs");
    rst = 1'b0;
    for (int e = 0; e < 4; e++) step();
    chk("rerun_x1", dut.r_regs[1], 32'd5);
    chk("rerun_x2", dut.r_regs[2], 32'd10);
    chk("rerun_x3", dut.r_regs[3], 32'd15);
    chk("rerun_x4", dut.r_regs[4], 32'hfffffffb);
    chk("rerun_pc", dut.r_pc, 32'h10);
    for (int i = 0; i < DW; i++) mm[i] = 32'd0;
    mm[2] = 32'd15;
    for (int p = 0; p < 3; p++) begin
      rst = 1'b1;
      gen_prog();
      load_prog();
      step();
      for (int i = 0; i < 32; i++) mr[i] = 32'd0;
      mpc = 32'd0;
      rst = 1'b0;
      for (int c = 0; c < 250; c++) begin
        model_step();
        step();
        chk($sformatf("rand%0d_c%0d_pc", p, c), dut.r_pc, mpc);
        chk_regs($sformatf("rand%0d_c%0d_regs", p, c));
      end
      begin
        int bad;
        bad = -1;
        checks++;
        for (int i = 0; i < DW; i++) if (bad < 0 && dut.r_dmem[i] !== mm[i]) bad = i;
        if (bad >= 0) begin
          failures++;
          $display("FAIL rand%0d_dmem: word %0d got %h want %h", p, bad, dut.r_dmem[bad], mm[bad]);
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
